tetris_siralayici: RTL and testbench
====================================

# tetris_siralayici

Piece sequencer and game controller placed in front of the `tetris` datapath. Buffers incoming piece codes in a small FIFO behind a valid/ready handshake. Issues exactly one piece per clock into `tetris.parca` while the game is running, and stops and locks out the datapath once `bitti_mi` is raised. It also counts issued pieces and flags a configurable stack-height warning.

## Interface
- `DERINLIK`, 4: FIFO depth in entries; power of two, ≥2.
- `ESIK`, 12: height threshold for `uyari`; range 0..15.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `baslat` in 1: start request, level-sampled.
- `duraklat` in 1: pause request, level-sampled.
- `giris_parca` in 3: incoming piece code.
- `giris_gecerli` in 1: `giris_parca` valid.
- `giris_hazir` out 1: FIFO can accept.
- `parca` out 3: registered piece code to `tetris.parca`.
- `yukseklik` in 4: stack height from `tetris`.
- `bitti_mi` in 1: game-over flag from `tetris`.
- `oyun_aktif` out 1: high in state AKTIF.
- `oyun_bitti` out 1: high in state BITTI.
- `yerlesen` out 8: count of non-zero pieces issued; saturating.
- `doluluk` out $clog2(DERINLIK)+1: FIFO occupancy.
- `uyari` out 1: registered `yukseklik >= ESIK`.

## Operation
- **States:** BOS (idle), AKTIF, BEKLE (paused), BITTI (game over).
- **BOS:**
  - `baslat=1` moves to AKTIF.
  - `parca=000`; no pops.
  - FIFO accepts pushes, so the queue can be preloaded.
- **AKTIF:**
  - `bitti_mi=1` moves to BITTI. This has priority over `duraklat`.
  - Otherwise `duraklat=1` moves to BEKLE.
  - Otherwise, each cycle: if the FIFO is non-empty, pop the head into `parca` and increment `yerlesen`. If the FIFO is empty, `parca` ← 000.
- **BEKLE:**
  - `parca=000`; no pops; pushes allowed.
  - `bitti_mi=1` moves to BITTI.
  - `duraklat=0` moves back to AKTIF.
- **BITTI:**
  - Terminal; left only by `rst`.
  - `parca=000`; `giris_hazir=0`; FIFO contents frozen.
- **Push handshake:**
  - A transfer occurs on an edge where `giris_gecerli && giris_hazir`.
  - `giris_hazir = !full && state!=BITTI`. It is combinational, with no dependence on `giris_gecerli`.
  - Code 000 is accepted but discarded: not stored, `doluluk` unchanged.
- **Simultaneous push and pop:**
  - When full: no push (ready is low), pop proceeds, `doluluk` drops by 1.
  - When empty: no bypass. The pushed piece is issued at the next edge at the earliest.
  - Otherwise, push and pop in the same cycle leave `doluluk` unchanged.
- **Pointers:** FIFO pointers wrap modulo `DERINLIK`.
- **`yerlesen`:** saturates at 255 and never wraps.
- **`uyari`:** updated every cycle in every state.
- **`baslat`:** ignored outside BOS.

## Timing
- **Reset values** (after the `rst` edge): state BOS, `parca=000`, FIFO empty, `doluluk=0`, `giris_hazir=1`, `oyun_aktif=0`, `oyun_bitti=0`, `yerlesen=0`, `uyari=0`.
- **Reset mid-operation:** returns to all reset values at the next edge, regardless of state or FIFO contents.
- **Issue latency:** the head of a non-empty FIFO in AKTIF appears on `parca` one edge later. A push into an empty FIFO at edge k appears on `parca` after edge k+1.
- **`baslat`:** `baslat` at edge k (BOS) sets `oyun_aktif` after edge k. The first pop occurs at edge k+1.
- **`bitti_mi`:** `bitti_mi` sampled high at edge k gives state BITTI and `parca=000` after edge k. The pop at edge k is suppressed.
- **`duraklat`:** `duraklat` sampled at edge k gives `parca=000` after edge k.
- **`uyari`:** lags `yukseklik` by one cycle.

## Configuration
- **`TETRIS_SIRALAYICI_LFSR_EN` defined:**
  - 8-bit LFSR, seed 8'hA5 on reset.
  - Polynomial x^8+x^6+x^5+x^4+1, Fibonacci form.
  - Advances every cycle in AKTIF only.
  - In AKTIF with an empty FIFO: `parca` ← `lfsr[2:0]`, with 000 mapped to 001. This counts toward `yerlesen`.
- **Undefined:** no LFSR logic; an empty FIFO in AKTIF issues 000.

## Test plan
- **Preload and issue:**
  - Stimulus: reset, then push 010, 011, 010 in BOS.
  - Check after pushes: `doluluk=3`.
  - Then assert `baslat`.
  - Required: `parca` shows 010, 011, 010 on three consecutive cycles, then 000 (macro off). `yerlesen=3`.
- **Full FIFO (`DERINLIK=4`):**
  - Stimulus: 5 pushes with `giris_gecerli` held high in BOS.
  - Required: `giris_hazir` low after the 4th push; `doluluk=4`.
  - Then assert `baslat`: the 5th piece is accepted only after the first pop.
- **Pause:**
  - Stimulus: `duraklat=1` for 3 cycles mid-stream.
  - Required: `parca=000` and `doluluk` unchanged while paused; issue resumes in order one cycle after release.
- **Game over:**
  - Stimulus: `bitti_mi=1` with 2 pieces queued.
  - Required: next cycle state BITTI, `parca=000`, `giris_hazir=0`, `doluluk=2` frozen.
  - `rst` then restores all reset values.
- **Discard and warning:**
  - Stimulus: push 000.
  - Required: `doluluk` unchanged.
  - Stimulus: drive `yukseklik=12` with `ESIK=12`.
  - Required: `uyari=1` one cycle later; `uyari=0` one cycle after `yukseklik=11`.
- **LFSR (macro defined):**
  - Stimulus: empty FIFO in AKTIF.
  - Required: `parca` is never 000; the sequence follows the seed A5; `yerlesen` increments every cycle.

Source files
------------

// File: rtl/tetris_siralayici.sv
// Piece sequencer for the tetris datapath: piece FIFO, game state machine, issue counter, height warning.
// Optional build macro TETRIS_SIRALAYICI_LFSR_EN: an empty FIFO in AKTIF issues pseudo-random pieces.
module tetris_siralayici #(
    parameter int unsigned DERINLIK = 4,
    parameter int unsigned ESIK     = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          baslat,
    input  logic                          duraklat,
    input  logic [2:0]                    giris_parca,
    input  logic                          giris_gecerli,
    output logic                          giris_hazir,
    output logic [2:0]                    parca,
    input  logic [3:0]                    yukseklik,
    input  logic                          bitti_mi,
    output logic                          oyun_aktif,
    output logic                          oyun_bitti,
    output logic [7:0]                    yerlesen,
    output logic [$clog2(DERINLIK):0]     doluluk,
    output logic                          uyari
);
    localparam int unsigned AW = $clog2(DERINLIK);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {BOS, AKTIF, BEKLE, BITTI} durum_t;

    durum_t         durum, durum_next;
    logic [2:0]     mem [DERINLIK];
    logic [AW-1:0]  rd_ptr, wr_ptr;
    logic           dolu, bos, akis, push, pop, say_artir;
    logic [2:0]     parca_next, yedek_parca;

    assign dolu        = (doluluk == CW'(DERINLIK));
    assign bos         = (doluluk == '0);
    assign giris_hazir = !dolu && (durum != BITTI);
    assign akis        = (durum == AKTIF) && !bitti_mi && !duraklat;
    assign pop         = akis && !bos;
    // Code 000 completes the handshake but is never stored.
    assign push        = giris_gecerli && giris_hazir && (giris_parca != 3'b000);

`ifdef TETRIS_SIRALAYICI_LFSR_EN
    logic [7:0] lfsr;

    // Fibonacci x^8+x^6+x^5+x^4+1, stepping only while the game runs.
    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= 8'hA5;
        else if (durum == AKTIF)
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign yedek_parca = (lfsr[2:0] == 3'b000) ? 3'b001 : lfsr[2:0];
`else
    assign yedek_parca = 3'b000;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            durum <= BOS;
        else
            durum <= durum_next;
    end

    always_comb begin
        durum_next = durum;
        parca_next = 3'b000;
        say_artir  = 1'b0;
        case (durum)
            BOS:   if (baslat) durum_next = AKTIF;
            AKTIF: begin
                if (bitti_mi)      durum_next = BITTI;
                else if (duraklat) durum_next = BEKLE;
            end
            BEKLE: begin
                if (bitti_mi)       durum_next = BITTI;
                else if (!duraklat) durum_next = AKTIF;
            end
            BITTI: durum_next = BITTI;
            default: durum_next = BOS;
        endcase
        if (akis) begin
            parca_next = pop ? mem[rd_ptr] : yedek_parca;
            say_artir  = (parca_next != 3'b000);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= giris_parca;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            doluluk    <= '0;
            parca      <= 3'b000;
            yerlesen   <= 8'd0;
            uyari      <= 1'b0;
            oyun_aktif <= 1'b0;
            oyun_bitti <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   doluluk <= doluluk + CW'(1);
                2'b01:   doluluk <= doluluk - CW'(1);
                default: doluluk <= doluluk;
            endcase
            parca <= parca_next;
            if (say_artir && (yerlesen != 8'hFF))
                yerlesen <= yerlesen + 8'd1;
            uyari      <= (yukseklik >= 4'(ESIK));
            oyun_aktif <= (durum_next == AKTIF);
            oyun_bitti <= (durum_next == BITTI);
        end
    end
endmodule

// File: tb/tb_tetris_siralayici.sv
// Self-checking bench for tetris_siralayici: directed scenarios plus a randomized run against a queue model.
module tb_tetris_siralayici;
    localparam int unsigned D = 4;

    logic       clk, rst, baslat, duraklat, giris_gecerli, bitti_mi;
    logic [2:0] giris_parca, parca;
    logic [3:0] yukseklik;
    logic       giris_hazir, oyun_aktif, oyun_bitti, uyari;
    logic [7:0] yerlesen;
    logic [2:0] doluluk;
    int n_chk, n_fail;

    tetris_siralayici #(.DERINLIK(D), .ESIK(12)) dut (
        .clk(clk), .rst(rst), .baslat(baslat), .duraklat(duraklat),
        .giris_parca(giris_parca), .giris_gecerli(giris_gecerli), .giris_hazir(giris_hazir),
        .parca(parca), .yukseklik(yukseklik), .bitti_mi(bitti_mi),
        .oyun_aktif(oyun_aktif), .oyun_bitti(oyun_bitti), .yerlesen(yerlesen),
        .doluluk(doluluk), .uyari(uyari)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        baslat = 0; duraklat = 0; giris_gecerli = 0; giris_parca = 0; bitti_mi = 0; yukseklik = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1; tick(); rst = 0;
    endtask

    task automatic push(input logic [2:0] v);
        giris_parca = v; giris_gecerli = 1; tick(); giris_gecerli = 0; giris_parca = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if (parca !== 3'd0) begin n_fail++; $display("FAIL reset_parca: got %0d want 0", parca); end
        n_chk++; if (doluluk !== 3'd0) begin n_fail++; $display("FAIL reset_doluluk: got %0d want 0", doluluk); end
        n_chk++; if (giris_hazir !== 1'b1) begin n_fail++; $display("FAIL reset_hazir: got %0d want 1", giris_hazir); end
        n_chk++; if (oyun_aktif !== 1'b0 || oyun_bitti !== 1'b0) begin n_fail++; $display("FAIL reset_state: aktif=%0d bitti=%0d want 0 0", oyun_aktif, oyun_bitti); end
        n_chk++; if (yerlesen !== 8'd0 || uyari !== 1'b0) begin n_fail++; $display("FAIL reset_cnt: yerlesen=%0d uyari=%0d want 0 0", yerlesen, uyari); end
    endtask

    task automatic test_preload();
        logic [2:0] exp_p [4];
        exp_p[0] = 3'd2; exp_p[1] = 3'd3; exp_p[2] = 3'd2; exp_p[3] = 3'd0;
        do_reset();
        push(3'd2); push(3'd3); push(3'd2);
        n_chk++; if (doluluk !== 3'd3) begin n_fail++; $display("FAIL preload_doluluk: got %0d want 3", doluluk); end
        n_chk++; if (parca !== 3'd0) begin n_fail++; $display("FAIL preload_idle_parca: got %0d want 0", parca); end
        baslat = 1; tick(); baslat = 0;
        n_chk++; if (oyun_aktif !== 1'b1 || parca !== 3'd0) begin n_fail++; $display("FAIL preload_start: aktif=%0d parca=%0d want 1 0", oyun_aktif, parca); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_chk++; if (parca !== exp_p[i]) begin n_fail++; $display("FAIL preload_issue%0d: got %0d want %0d", i, parca, exp_p[i]); end
        end
        n_chk++; if (yerlesen !== 8'd3) begin n_fail++; $display("FAIL preload_yerlesen: got %0d want 3", yerlesen); end
    endtask

    task automatic test_full();
        logic [2:0] exp_p [6];
        exp_p[0] = 3'd1; exp_p[1] = 3'd2; exp_p[2] = 3'd3; exp_p[3] = 3'd4; exp_p[4] = 3'd5; exp_p[5] = 3'd0;
        do_reset();
        giris_gecerli = 1;
        for (int i = 1; i <= 4; i++) begin giris_parca = 3'(i); tick(); end
        giris_parca = 3'd5;
        n_chk++; if (giris_hazir !== 1'b0 || doluluk !== 3'd4) begin n_fail++; $display("FAIL full_after4: hazir=%0d doluluk=%0d want 0 4", giris_hazir, doluluk); end
        tick();
        n_chk++; if (doluluk !== 3'd4) begin n_fail++; $display("FAIL full_blocked: doluluk=%0d want 4", doluluk); end
        baslat = 1; tick(); baslat = 0;
        n_chk++; if (doluluk !== 3'd4 || giris_hazir !== 1'b0) begin n_fail++; $display("FAIL full_start: doluluk=%0d hazir=%0d want 4 0", doluluk, giris_hazir); end
        tick();
        n_chk++; if (parca !== 3'd1 || doluluk !== 3'd3) begin n_fail++; $display("FAIL full_firstpop: parca=%0d doluluk=%0d want 1 3", parca, doluluk); end
        tick(); giris_gecerli = 0; giris_parca = 0;
        n_chk++; if (parca !== 3'd2 || doluluk !== 3'd3) begin n_fail++; $display("FAIL full_pushpop: parca=%0d doluluk=%0d want 2 3", parca, doluluk); end
        for (int i = 2; i < 6; i++) begin
            tick();
            n_chk++; if (parca !== exp_p[i]) begin n_fail++; $display("FAIL full_drain%0d: got %0d want %0d", i, parca, exp_p[i]); end
        end
    endtask

    task automatic test_pause();
        do_reset();
        push(3'd1); push(3'd2); push(3'd3); push(3'd4);
        baslat = 1; tick(); baslat = 0;
        tick();
        n_chk++; if (parca !== 3'd1 || doluluk !== 3'd3) begin n_fail++; $display("FAIL pause_pre: parca=%0d doluluk=%0d want 1 3", parca, doluluk); end
        duraklat = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++; if (parca !== 3'd0 || doluluk !== 3'd3 || oyun_aktif !== 1'b0) begin n_fail++; $display("FAIL pause_hold%0d: parca=%0d doluluk=%0d aktif=%0d want 0 3 0", i, parca, doluluk, oyun_aktif); end
        end
        duraklat = 0; tick();
        n_chk++; if (parca !== 3'd0 || oyun_aktif !== 1'b1) begin n_fail++; $display("FAIL pause_release: parca=%0d aktif=%0d want 0 1", parca, oyun_aktif); end
        for (int i = 2; i <= 4; i++) begin
            tick();
            n_chk++; if (parca !== 3'(i)) begin n_fail++; $display("FAIL pause_resume%0d: got %0d want %0d", i, parca, i); end
        end
    endtask

    task automatic test_game_over();
        do_reset();
        push(3'd1); push(3'd2); push(3'd3); push(3'd4);
        baslat = 1; tick(); baslat = 0;
        tick(); tick();
        bitti_mi = 1; tick();
        n_chk++; if (oyun_bitti !== 1'b1 || oyun_aktif !== 1'b0 || parca !== 3'd0) begin n_fail++; $display("FAIL over_state: bitti=%0d aktif=%0d parca=%0d want 1 0 0", oyun_bitti, oyun_aktif, parca); end
        n_chk++; if (giris_hazir !== 1'b0 || doluluk !== 3'd2) begin n_fail++; $display("FAIL over_fifo: hazir=%0d doluluk=%0d want 0 2", giris_hazir, doluluk); end
        bitti_mi = 0; giris_gecerli = 1; giris_parca = 3'd5; baslat = 1; tick(); tick();
        n_chk++; if (oyun_bitti !== 1'b1 || doluluk !== 3'd2 || parca !== 3'd0) begin n_fail++; $display("FAIL over_frozen: bitti=%0d doluluk=%0d parca=%0d want 1 2 0", oyun_bitti, doluluk, parca); end
        idle_inputs(); rst = 1; tick(); rst = 0;
        n_chk++; if (oyun_bitti !== 1'b0 || doluluk !== 3'd0 || giris_hazir !== 1'b1 || yerlesen !== 8'd0) begin n_fail++; $display("FAIL over_reset: bitti=%0d doluluk=%0d hazir=%0d yerlesen=%0d want 0 0 1 0", oyun_bitti, doluluk, giris_hazir, yerlesen); end
    endtask

    task automatic test_discard_warning();
        do_reset();
        push(3'd0);
        n_chk++; if (doluluk !== 3'd0) begin n_fail++; $display("FAIL discard_empty: doluluk=%0d want 0", doluluk); end
        push(3'd6); push(3'd0);
        n_chk++; if (doluluk !== 3'd1) begin n_fail++; $display("FAIL discard_one: doluluk=%0d want 1", doluluk); end
        yukseklik = 4'd12; #1;
        n_chk++; if (uyari !== 1'b0) begin n_fail++; $display("FAIL warn_lag: uyari=%0d want 0", uyari); end
        tick();
        n_chk++; if (uyari !== 1'b1) begin n_fail++; $display("FAIL warn_12: uyari=%0d want 1", uyari); end
        yukseklik = 4'd11; tick();
        n_chk++; if (uyari !== 1'b0) begin n_fail++; $display("FAIL warn_11: uyari=%0d want 0", uyari); end
        yukseklik = 4'd15; tick();
        n_chk++; if (uyari !== 1'b1) begin n_fail++; $display("FAIL warn_15: uyari=%0d want 1", uyari); end
    endtask

    task automatic test_saturation();
        do_reset();
        baslat = 1; tick(); baslat = 0;
        giris_gecerli = 1;
        for (int i = 0; i < 270; i++) begin giris_parca = 3'(1 + (i % 7)); tick(); end
        giris_gecerli = 0; giris_parca = 0;
        n_chk++; if (yerlesen !== 8'd255) begin n_fail++; $display("FAIL saturate: yerlesen=%0d want 255", yerlesen); end
    endtask

    task automatic test_random();
        int st, mc, mu, bs, dr, bt, gv, rs;
        logic [2:0] q[$];
        logic [2:0] mp, gp;
        logic [7:0] ml;
        logic [3:0] yk;
        logic hz;
        do_reset();
        st = 0; mc = 0; mu = 0; mp = 0; ml = 8'hA5;
        for (int i = 0; i < 800; i++) begin
            rs = int'($urandom_range(99) < 2);
            bs = int'($urandom_range(99) < 25);
            dr = int'($urandom_range(99) < 15);
            bt = int'($urandom_range(99) < 2);
            gv = int'($urandom_range(99) < 60);
            gp = 3'($urandom_range(7));
            yk = 4'($urandom_range(15));
            rst = rs[0]; baslat = bs[0]; duraklat = dr[0]; bitti_mi = bt[0];
            giris_gecerli = gv[0]; giris_parca = gp; yukseklik = yk;
            hz = (st != 3) && (q.size() < D);
            #1;
            n_chk++; if (giris_hazir !== hz) begin n_fail++; $display("FAIL rnd_hazir@%0d: got %0d want %0d", i, giris_hazir, hz); end
            tick();
            if (rs != 0) begin
                st = 0; q.delete(); mp = 0; mc = 0; mu = 0; ml = 8'hA5;
            end else begin
                mp = 0;
                if (st == 1 && bt == 0 && dr == 0) begin
                    if (q.size() > 0) mp = q.pop_front();
`ifdef TETRIS_SIRALAYICI_LFSR_EN
                    else mp = (ml[2:0] == 3'd0) ? 3'd1 : ml[2:0];
`endif
                    if (mp != 0 && mc < 255) mc++;
                end
`ifdef TETRIS_SIRALAYICI_LFSR_EN
                if (st == 1) ml = {ml[6:0], ml[7] ^ ml[5] ^ ml[4] ^ ml[3]};
`endif
                if (gv != 0 && hz && gp != 0) q.push_back(gp);
                mu = int'(yk >= 4'd12);
                case (st)
                    0: if (bs != 0) st = 1;
                    1: if (bt != 0) st = 3; else if (dr != 0) st = 2;
                    2: if (bt != 0) st = 3; else if (dr == 0) st = 1;
                    default: st = 3;
                endcase
            end
            n_chk++; if (parca !== mp) begin n_fail++; $display("FAIL rnd_parca@%0d: got %0d want %0d", i, parca, mp); end
            n_chk++; if (int'(doluluk) != q.size()) begin n_fail++; $display("FAIL rnd_doluluk@%0d: got %0d want %0d", i, doluluk, q.size()); end
            n_chk++; if (int'(yerlesen) != mc) begin n_fail++; $display("FAIL rnd_yerlesen@%0d: got %0d want %0d", i, yerlesen, mc); end
            n_chk++; if (int'(uyari) != mu) begin n_fail++; $display("FAIL rnd_uyari@%0d: got %0d want %0d", i, uyari, mu); end
            n_chk++; if (oyun_aktif !== (st == 1) || oyun_bitti !== (st == 3)) begin n_fail++; $display("FAIL rnd_state@%0d: aktif=%0d bitti=%0d model_state=%0d", i, oyun_aktif, oyun_bitti, st); end
        end
        idle_inputs(); rst = 0;
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst = 0; idle_inputs();
        test_reset();
`ifndef TETRIS_SIRALAYICI_LFSR_EN
        test_preload();
        test_full();
        test_pause();
        test_saturation();
`endif
        test_game_over();
        test_discard_warning();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
